// File: rtl/cpu_defs.sv
// Shared encodings for the EX-stage multiply/divide sequencer: ALU op codes,
// sequencer FSM states and the internal op selector.
package cpu_defs;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_MUL  = 3'd4,
        ALU_DIVU = 3'd5,
        ALU_REMU = 3'd6
    } aluctr_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_e;

    function automatic logic is_md_op(input logic [2:0] code);
        return (code == ALU_MUL) || (code == ALU_DIVU) || (code == ALU_REMU);
    endfunction

    function automatic md_op_e decode_md_op(input logic [2:0] code);
        if (code == ALU_MUL)
            return MD_MUL;
        else if (code == ALU_DIVU)
            return MD_DIVU;
        else
            return MD_REMU;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring unsigned divide.
// Divide keeps the partial remainder in acc and shifts quotient bits into a_sh.
module muldiv_step
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a_sh,
    input  logic [WIDTH-1:0] b_sh,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] a_sh_nxt,
    output logic [WIDTH-1:0] b_sh_nxt
);

    logic [WIDTH:0] trial;

    always_comb begin
        acc_nxt  = acc;
        a_sh_nxt = a_sh;
        b_sh_nxt = b_sh;
        trial    = '0;
        if (op == MD_MUL) begin
            acc_nxt  = acc + (b_sh[0] ? a_sh : '0);
            a_sh_nxt = {a_sh[WIDTH-2:0], 1'b0};
            b_sh_nxt = {1'b0, b_sh[WIDTH-1:1]};
        end else begin
            // Remainder stays below the divisor, so the top bit of trial is the borrow.
            trial = {acc, a_sh[WIDTH-1]} - {1'b0, b_sh};
            if (!trial[WIDTH]) begin
                acc_nxt  = trial[WIDTH-1:0];
                a_sh_nxt = {a_sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt  = {acc[WIDTH-2:0], a_sh[WIDTH-1]};
                a_sh_nxt = {a_sh[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/exec_muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer beside the EX stage: stalls the front end
// while it iterates and presents a one-cycle result to the XM writeback mux.
module exec_muldiv_seq
    import cpu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [2:0]       ALUctr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       DX_RD,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             md_valid,
    output logic [WIDTH-1:0] md_result,
    output logic [4:0]       md_rd,
    output md_state_e        state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, a_sh, b_sh;
    md_op_e           op;
    logic [4:0]       rd;
    logic             div0;

    logic [WIDTH-1:0] step_acc, step_a, step_b;
    logic [WIDTH-1:0] result;
    logic             accept, last, finish_op;
    md_op_e           op_in;
    logic             div0_in;

    // Handshake: an op is taken when issue is high with one of our codes in IDLE
    // and no flush; upstream holds it (stall) until then and re-presents it.
    assign op_in     = decode_md_op(ALUctr);
    assign div0_in   = (B == '0) && (op_in != MD_MUL);
    assign accept    = (state == ST_IDLE) && issue && is_md_op(ALUctr) && !flush;
    assign last      = (cnt == CNT_LAST);
    assign finish_op = (state == ST_RUN) && last && !flush;
    assign state_dbg = state;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op),
        .acc      (acc),
        .a_sh     (a_sh),
        .b_sh     (b_sh),
        .acc_nxt  (step_acc),
        .a_sh_nxt (step_a),
        .b_sh_nxt (step_b)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush)
                    state_nxt = ST_IDLE;
                else if (last)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall = rst && (accept || ((state == ST_RUN) && !flush));
    end

    // A zero divisor skips the loop: one RUN cycle, then the fixed x/0 answer.
    always_comb begin
        result = step_acc;
        case (op)
            MD_MUL:  result = step_acc;
            MD_DIVU: result = div0 ? '1 : step_a;
            MD_REMU: result = div0 ? acc : step_acc;
            default: result = step_acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            op        <= MD_MUL;
            rd        <= '0;
            div0      <= 1'b0;
            busy      <= 1'b0;
            md_valid  <= 1'b0;
            md_result <= '0;
            md_rd     <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != ST_IDLE);
            md_valid <= finish_op;
            if (accept) begin
                a_sh <= A;
                b_sh <= B;
                acc  <= div0_in ? A : '0;
                op   <= op_in;
                rd   <= DX_RD;
                div0 <= div0_in;
                cnt  <= div0_in ? CNT_LAST : '0;
            end else if (state == ST_RUN) begin
                acc  <= step_acc;
                a_sh <= step_a;
                b_sh <= step_b;
                cnt  <= cnt + 1'b1;
            end
            if (finish_op) begin
                md_result <= result;
                md_rd     <= rd;
            end
        end
    end

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Directed bench for exec_muldiv_seq: the driver pushes expected results and
// their due cycle; an independent monitor pops them whenever md_valid fires.
module tb_exec_muldiv_seq;
    import cpu_defs::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue;
    logic [2:0]    ALUctr;
    logic [W-1:0]  A, B;
    logic [4:0]    DX_RD;
    logic          flush;
    logic          stall, busy, md_valid;
    logic [W-1:0]  md_result;
    logic [4:0]    md_rd;
    md_state_e     state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_t = 0;

    logic [W+4:0] exp_q[$];
    int           exp_cyc_q[$];
    logic         prev_valid = 1'b0;

    exec_muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .ALUctr    (ALUctr),
        .A         (A),
        .B         (B),
        .DX_RD     (DX_RD),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .md_valid  (md_valid),
        .md_result (md_result),
        .md_rd     (md_rd),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (md_valid) begin
                check("valid_not_back_to_back", W'(prev_valid), W'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", W'(1), W'(0));
                end else begin
                    logic [W+4:0] e;
                    int           ec;
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("md_result", md_result, e[W-1:0]);
                    check("md_rd", W'(md_rd), W'(e[W+4:W]));
                    check("valid_cycle", W'(cyc), W'(ec));
                end
            end
            prev_valid = md_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Drives one op starting at the current time, waits for acceptance, then
    // checks stall over the whole run and its drop in the DONE cycle.
    task automatic run_op(input logic [2:0] ctr, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input logic [W-1:0] exp_res, input int lat,
                          input string name);
        int   waits;
        logic stall_ok;
        issue  = 1'b1;
        ALUctr = ctr;
        A      = a;
        B      = b;
        DX_RD  = rd;
        #1;
        waits = 0;
        while (!stall && waits < 4) begin
            @(negedge clk); #1;
            waits++;
        end
        check({name, "_accept"}, W'(stall), W'(1));
        last_t = cyc;
        exp_q.push_back({rd, exp_res});
        exp_cyc_q.push_back(cyc + lat);
        @(negedge clk);
        issue = 1'b0;
        #1;
        stall_ok = 1'b1;
        for (int k = 1; k < lat; k++) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clk); #1;
        end
        check({name, "_stall_run"}, W'(stall_ok), W'(1));
        check({name, "_stall_done"}, W'(stall), W'(0));
        check({name, "_busy_done"}, W'(busy), W'(1));
    endtask

    initial begin
        int t0;
        int n;
        rst    = 1'b0;
        issue  = 1'b1;
        ALUctr = 3'd4;
        A      = 32'd7;
        B      = 32'd6;
        DX_RD  = 5'd1;
        flush  = 1'b0;
        #12;
        check("rst_stall", W'(stall), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_valid", W'(md_valid), W'(0));
        check("rst_result", md_result, W'(0));
        check("rst_state", W'(state_dbg), W'(0));
        issue = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: basic MUL, 2: wraparound MUL
        run_op(3'd4, 32'd7, 32'd6, 5'd3, 32'd42, 33, "mul_7x6");
        @(negedge clk);
        run_op(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 33, "mul_ones");
        @(negedge clk);
        run_op(3'd4, 32'h1234_5678, 32'h10, 5'd0, 32'h2345_6780, 33, "mul_rd0");

        // 3: back-to-back divide, second presented during DONE
        @(negedge clk);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, "divu_100_7");
        t0 = last_t;
        run_op(3'd6, 32'd100, 32'd7, 5'd8, 32'd2, 33, "remu_100_7");
        check("b2b_accept_cycle", W'(last_t), W'(t0 + 34));
        @(negedge clk);
        run_op(3'd6, 32'h8000_0000, 32'd3, 5'd12, 32'd2, 33, "remu_big");
        @(negedge clk);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 33, "divu_by1");

        // 4: divide by zero
        @(negedge clk);
        run_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2, "divu_5_0");
        @(negedge clk);
        run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 2, "remu_5_0");

        // 5: flush mid-MUL, then a new op right after
        @(negedge clk);
        issue  = 1'b1;
        ALUctr = 3'd4;
        A      = 32'd3;
        B      = 32'd3;
        DX_RD  = 5'd4;
        t0     = cyc;
        @(negedge clk);
        issue = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall_drop", W'(stall), W'(0));
        check("flush_cycle", W'(cyc), W'(t0 + 10));
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy_clear", W'(busy), W'(0));
        run_op(3'd5, 32'd9, 32'd3, 5'd11, 32'd3, 33, "divu_9_3");
        check("flush_new_accept", W'(last_t), W'(t0 + 11));

        // flush coincident with issue is not accepted
        @(negedge clk);
        issue  = 1'b1;
        ALUctr = 3'd5;
        flush  = 1'b1;
        #1;
        check("flush_issue_stall", W'(stall), W'(0));
        @(negedge clk);
        issue = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_issue_busy", W'(busy), W'(0));

        // 6: asynchronous reset mid-DIVU
        @(negedge clk);
        issue  = 1'b1;
        ALUctr = 3'd5;
        A      = 32'd50;
        B      = 32'd5;
        DX_RD  = 5'd6;
        @(negedge clk);
        issue = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_stall", W'(stall), W'(0));
        check("arst_busy", W'(busy), W'(0));
        check("arst_result", md_result, W'(0));
        check("arst_rd", W'(md_rd), W'(0));
        check("arst_state", W'(state_dbg), W'(0));
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (stall || busy) n++;
        end
        check("post_rst_idle", W'(n), W'(0));
        issue  = 1'b1;
        ALUctr = 3'd0;
        #1;
        check("add_no_stall", W'(stall), W'(0));
        @(negedge clk);
        issue = 1'b0;
        #1;
        check("add_no_busy", W'(busy), W'(0));

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", W'(exp_q.size()), W'(0));
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
